// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and prescaler helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    function automatic int prescale_div(input int clock_freq, input int baud_rate,
                                        input int oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick prescaler: one-clk tick every DIVIDE clocks, synchronous clear realigns the phase.
module uart_baud_gen #(
    parameter int DIVIDE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames and get a parity_err output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIVIDE = prescale_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] HALF_BIT = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_BIT = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rx_meta_reg, rx_s_reg;
    logic baud_clr, tick;

    rx_state_t                 state_reg, state_next;
    logic [TICK_W-1:0]         tick_cnt_reg, tick_cnt_next;
    logic [2:0]                bit_cnt_reg, bit_cnt_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic                      wait_high_reg, wait_high_next;
    logic                      done_reg, done_next;
    logic                      frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                      parity_bit_reg, parity_bit_next;
    logic                      parity_err_next;
    logic                      parity_bad;

    assign parity_bad = (^{shift_reg, parity_bit_reg}) != (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    uart_baud_gen #(
        .DIVIDE (DIVIDE)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            wait_high_reg  <= 1'b0;
            done_reg       <= 1'b0;
            frame_err      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            wait_high_reg  <= wait_high_next;
            done_reg       <= done_next;
            frame_err      <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err     <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        wait_high_next  = wait_high_reg;
        done_next       = 1'b0;
        frame_err_next  = 1'b0;
        baud_clr        = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // Holding the prescaler in clear while idle aligns ticks to the start edge.
                baud_clr      = 1'b1;
                tick_cnt_next = '0;
                bit_cnt_next  = '0;
                if (wait_high_reg) begin
                    if (rx_s_reg) wait_high_next = 1'b0;
                end else if (!rx_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_reg == HALF_BIT) begin
                        tick_cnt_next = '0;
                        state_next    = rx_s_reg ? IDLE : DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_reg == FULL_BIT) begin
                        tick_cnt_next = '0;
                        shift_next    = {rx_s_reg, shift_reg[UART_DATA_BITS-1:1]};
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_reg == FULL_BIT) begin
                        tick_cnt_next   = '0;
                        parity_bit_next = rx_s_reg;
                        state_next      = STOP;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_reg == FULL_BIT) begin
                        tick_cnt_next = '0;
                        state_next    = IDLE;
                        if (!rx_s_reg) begin
                            frame_err_next = 1'b1;
                            wait_high_next = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (parity_bad) begin
                            parity_err_next = 1'b1;
                        end
`endif
                        else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A completed byte may replace the held one only if it is empty or being consumed now.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_reg) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
